// File: rtl/zc_pkg.sv
// Shared types and constants for the zero-check scheduler.
package zc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StResp
    } zc_state_t;

    // Requester ids, also the bit positions in req_*/resp_* vectors.
    localparam logic ZC_REQ_FLAG = 1'b0;
    localparam logic ZC_REQ_CBZ  = 1'b1;

    localparam int unsigned ZC_SETTLE = 4;

    function automatic logic [1:0] zc_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/check_zero.sv
// Ripple zero detector: a chained OR across the operand. Slow (multi-cycle) by nature.
module check_zero #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] op,
    output logic             zero
);

    logic any_set;

    // Walk the operand bit by bit so the OR chain stays a single ripple path.
    always_comb begin
        any_set = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            any_set = any_set | op[i];
        end
        zero = ~any_set;
    end

endmodule

// File: rtl/zero_check_sched.sv
// Time-shares one slow zero detector between the flag path and the CBZ path.
module zero_check_sched
    import zc_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned SETTLE = ZC_SETTLE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req_valid,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    output logic [1:0]       req_ready,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic             resp_zero,
    input  logic             flush,
    output logic             busy
);

    localparam int unsigned    CW       = $clog2(SETTLE) + 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(SETTLE - 1);

    zc_state_t       state_q, state_d;
    logic [WIDTH-1:0] op_q;
    logic [CW-1:0]   cnt_q;
    logic            zero_q;
    logic            gid_q;
    logic            last_q;

    logic            grant_id;
    logic            accept;
    logic            cbz_flush;
    logic            settle_done;
    logic            det_zero;

    check_zero #(
        .WIDTH (WIDTH)
    ) u_check_zero (
        .op   (op_q),
        .zero (det_zero)
    );

    // Round-robin pick: on a tie, grant the requester not served last time.
    always_comb begin
        if (req_valid == 2'b11) begin
            grant_id = ~last_q;
        end else begin
            grant_id = req_valid[1];
        end
    end

    assign accept      = (state_q == StIdle) && (req_valid != 2'b00);
    assign cbz_flush   = flush && (gid_q == ZC_REQ_CBZ);
    assign settle_done = (cnt_q == '0);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a CBZ flush abandons the operation without a response.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StSettle;
            end
            StSettle: begin
                if (cbz_flush)        state_d = StIdle;
                else if (settle_done) state_d = StResp;
            end
            StResp: begin
                if (cbz_flush || resp_ready[gid_q]) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs; req_ready is also forced low while reset is held.
    always_comb begin
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        resp_zero  = 1'b0;
        busy       = (state_q != StIdle);
        if (state_q == StIdle && reset_n && req_valid != 2'b00) begin
            req_ready = zc_onehot(grant_id);
        end
        if (state_q == StResp) begin
            resp_valid = zc_onehot(gid_q);
            resp_zero  = zero_q;
        end
    end

    // Capture operand and grant on acceptance so later data changes cannot leak in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q   <= '0;
            gid_q  <= 1'b0;
            last_q <= 1'b1;
        end else if (accept) begin
            op_q   <= grant_id ? req_data1 : req_data0;
            gid_q  <= grant_id;
            last_q <= grant_id;
        end
    end

    // Settle countdown: loads SETTLE-1 on acceptance, counts down to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= CNT_LOAD;
        end else if (state_q == StSettle && !settle_done) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Sample the detector only once its ripple has settled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zero_q <= 1'b0;
        end else if (state_q == StSettle && settle_done) begin
            zero_q <= det_zero;
        end
    end

endmodule

// File: doc/zero_check_sched.md
# zero_check_sched

Scheduler that time-shares one 64-bit ripple zero detector (`check_zero`) between two requesters: the flag path (Z for flag-setting ALU results) and the CBZ path (branch operand test). The detector's chained-OR delay spans several clock periods, so this block registers the operand, waits a fixed settle count, samples the result, and returns it over a valid/ready handshake. It sits between EX (flag writeback) and branch resolution.

## Interface
- `WIDTH`, default 64: operand width.
- `SETTLE`, default 4: clock cycles the detector output needs after its operand register loads. Minimum 1.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 2: bit 0 is the flag requester, bit 1 is the CBZ requester.
- `req_data0` in WIDTH: flag-path operand. Held stable while `req_valid[0]` is high.
- `req_data1` in WIDTH: CBZ operand. Held stable while `req_valid[1]` is high.
- `req_ready` out 2: one-hot grant. A request is accepted when `req_valid[i]` and `req_ready[i]` are both high at an edge.
- `resp_valid` out 2: result available for requester i.
- `resp_ready` in 2: requester i consumes its result.
- `resp_zero` out 1: 1 when the accepted operand was all zeros. Meaningful only while a `resp_valid` bit is high.
- `flush` in 1: cancels any pending CBZ operation.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE
  - SETTLE: a countdown counter `cnt`, width clog2(SETTLE)+1.
  - RESP
- IDLE:
  - If any `req_valid` bit is high, `req_ready` is driven combinationally for the granted requester only.
  - On acceptance: load the operand register `op` from the granted data, store `gid` (granted id), load `cnt`=SETTLE-1, and go to SETTLE.
  - `req_ready` is 0 in every other state.
- Arbitration is round-robin on a one-bit pointer `last` (the previously granted id).
  - When both requesters are valid, grant `~last`.
  - When one is valid, grant that one.
  - `last` updates on acceptance only.
- SETTLE:
  - Decrement `cnt` each cycle.
  - In the cycle where `cnt`==0, register the detector output into `zero_q` and go to RESP.
- RESP:
  - `resp_valid[gid]`=1 and `resp_zero`=`zero_q`; the other `resp_valid` bit is 0.
  - Hold until `resp_ready[gid]`, then go to IDLE.
  - A new request cannot be accepted in the same cycle as the response handshake.
- `flush`:
  - In SETTLE or RESP with `gid`==1: return to IDLE next cycle with no response.
  - In those states with `gid`==0: ignored.
  - In IDLE: no effect. A CBZ request presented in the same cycle as `flush` is still accepted; the requester is responsible for dropping `req_valid`.
- `resp_ready` is ignored outside RESP, and the bit for the non-granted id is ignored.
- Operand changes on `req_data*` after acceptance do not affect the result.

## Timing
- Reset values (asynchronous, while `reset_n`=0):
  - Registers: state IDLE, `op`=0, `cnt`=0, `zero_q`=0, `gid`=0, `last`=1, so requester 0 wins the first tie.
  - Outputs: `req_ready`=0, `resp_valid`=0, `resp_zero`=0, `busy`=0.
- Latency: request accepted at edge E. SETTLE occupies the SETTLE cycles after E, and `resp_valid` is first high SETTLE cycles after E.
- With `resp_ready` held high, the minimum time between acceptances is SETTLE+2 cycles.
- SETTLE=1: `cnt` loads 0, so the block spends exactly one cycle in SETTLE.
- `reset_n` asserted mid-operation: the operation is abandoned immediately and no response is produced after release.

## Structure
- Package `zc_pkg`:
  - State enum `zc_state_t` (IDLE, SETTLE, RESP).
  - Requester ids `ZC_REQ_FLAG`=0 and `ZC_REQ_CBZ`=1.
  - Default `ZC_SETTLE`=4.
- One sub-module: a single `check_zero` instance driven only by `op`. Its output is sampled only in the final SETTLE cycle.
- `op` is a flip-flop register, so the detector input changes only on acceptance edges.

## Test plan
1. Reset: hold `reset_n`=0 for 3 cycles with `req_valid`=2'b11 → all outputs 0. After release, the first grant goes to requester 0.
2. Flag path: `req_data0`=0, SETTLE=4 → `req_ready[0]` high in the request cycle; `resp_valid[0]` high 4 cycles after the accept edge with `resp_zero`=1. Hold `resp_ready[0]`=0 for 3 cycles → outputs stable; IDLE the cycle after `resp_ready[0]`=1.
3. CBZ path: `req_data1`=497403948 → `resp_valid[1]` with `resp_zero`=0. Then `req_data1`=64'h8000_0000_0000_0000 → `resp_zero`=0. Then `req_data1`=0 → `resp_zero`=1.
4. Round-robin: both valid continuously for three operations → grant order 0, 1, 0. No `resp_valid` bit other than `gid` ever rises.
5. Flush: accept CBZ, pulse `flush` in the second SETTLE cycle with `req_valid[0]` pending → no `resp_valid[1]`; IDLE next cycle; `req_data0` accepted the following cycle.
6. Async reset mid-SETTLE: drop `reset_n` between edges → `busy`, `resp_valid` and `req_ready` go to 0 immediately. After release, a fresh request completes normally.
